crossing_fsm: RTL and testbench

//   Level-crossing sequencer for the train controller; sits directly upstream of the lamp/alarm/barrier decoder.

---
 rtl/crossing_fsm.sv | 162 ++++++++++++++++
 tb/tb_crossing_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/crossing_fsm.sv
// Level-crossing sequencer: sensor sync, dwell timing, state code to decoder.
// Optional sensor debounce filter enabled with `define DEBOUNCE_EN.
module crossing_fsm #(
    parameter int T_WARN    = 8,
    parameter int T_AMBER   = 8,
    parameter int T_TIMEOUT = 64,
    parameter int T_RAISE   = 4,
    parameter int CNT_W     = 8
`ifdef DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_a,
    input  logic       s_b,
    input  logic       s_c,
    output logic [0:3] present_state,
    output logic       y,
    output logic       dir,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE, DETECT, ALERT, CLOSED, OCCUPIED, CLEARED, ABORT
    } state_t;

    localparam logic [CNT_W-1:0] WARN_L  = CNT_W'(T_WARN - 1);
    localparam logic [CNT_W-1:0] AMBER_L = CNT_W'(T_AMBER - 1);
    localparam logic [CNT_W-1:0] TO_L    = CNT_W'(T_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RAISE_L = CNT_W'(T_RAISE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, next;
    logic [CNT_W-1:0] cnt;
    logic             flag, flag_n;
    logic             dir_n, fault_n;
    logic [3:0]       code_n;
    logic             y_n;
    logic             timed;
    logic [2:0]       meta, sync, sens;
    logic             sa, sb, sc, ex;

    // two-flop synchronizer, bit order {s_a, s_b, s_c}
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {s_a, s_b, s_c};
            sync <= meta;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic          f_q;
        logic [DW-1:0] c_q;
        // filtered level flips after DEB_CYCLES consecutive differing samples
        always_ff @(posedge clk) begin
            if (rst) begin
                f_q <= 1'b0;
                c_q <= '0;
            end else if (sync[i] != f_q) begin
                if (c_q == DW'(DEB_CYCLES - 1)) begin
                    f_q <= ~f_q;
                    c_q <= '0;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end else begin
                c_q <= '0;
            end
        end
        assign sens[i] = f_q;
    end
`else
    assign sens = sync;
`endif

    assign sa = sens[2];
    assign sb = sens[1];
    assign sc = sens[0];
    assign ex = dir ? sa : sb;

    assign timed = (state == DETECT) || (state == ALERT) ||
                   (state == CLOSED) || (state == CLEARED) ||
                   (state == ABORT);

    // next-state, sticky flags and decoder code for the next state
    always_comb begin
        next    = state;
        dir_n   = dir;
        flag_n  = flag;
        fault_n = fault;
        code_n  = 4'b0000;
        y_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sa) begin
                    next  = DETECT;
                    dir_n = 1'b0;
                end else if (sb) begin
                    next  = DETECT;
                    dir_n = 1'b1;
                end else if (sc) begin
                    next  = DETECT;
                    dir_n = 1'b0;
                end
            end
            DETECT:   if (cnt == WARN_L) next = ALERT;
            ALERT:    if (cnt == AMBER_L) next = CLOSED;
            CLOSED: begin
                if (sc) next = OCCUPIED;
                else if (cnt == TO_L) next = ABORT;
            end
            OCCUPIED: begin
                if (flag && !sc) next = CLEARED;
                else if (ex) flag_n = 1'b1;
            end
            CLEARED:  if (cnt == RAISE_L) next = IDLE;
            ABORT:    if (cnt == RAISE_L) next = IDLE;
            default:  next = IDLE;
        endcase
        if (next == OCCUPIED && state != OCCUPIED) flag_n = 1'b0;
        if (next == ABORT && state != ABORT) fault_n = 1'b1;
        unique case (next)
            DETECT:   code_n = 4'b0011;
            ALERT:    code_n = 4'b0100;
            CLOSED:   code_n = 4'b0110;
            OCCUPIED: begin code_n = 4'b0110; y_n = 1'b1; end
            CLEARED:  begin code_n = 4'b1010; y_n = 1'b1; end
            ABORT:    begin code_n = 4'b1011; y_n = 1'b1; end
            default:  code_n = 4'b0000;
        endcase
    end

    // state, dwell counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            flag          <= 1'b0;
            dir           <= 1'b0;
            fault         <= 1'b0;
            present_state <= 4'b0000;
            y             <= 1'b0;
        end else begin
            state         <= next;
            flag          <= flag_n;
            dir           <= dir_n;
            fault         <= fault_n;
            present_state <= code_n;
            y             <= y_n;
            if (next != state) cnt <= '0;
            else if (timed && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_crossing_fsm.sv
// Scoreboard bench for crossing_fsm: directed sensor sequences.
// Expected codes are queued per cycle; a negedge monitor compares them.
module tb_crossing_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_a, s_b, s_c;
    logic [0:3] ps;
    logic       y, dir, fault;

    crossing_fsm dut (
        .clk(clk), .rst(rst), .s_a(s_a), .s_b(s_b), .s_c(s_c),
        .present_state(ps), .y(y), .dir(dir), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic       y;
        logic       d;
        logic       f;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] C_IDLE = 4'b0000;
    localparam logic [3:0] C_DET  = 4'b0011;
    localparam logic [3:0] C_ALE  = 4'b0100;
    localparam logic [3:0] C_CLO  = 4'b0110;
    localparam logic [3:0] C_CLR  = 4'b1010;
    localparam logic [3:0] C_ABT  = 4'b1011;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every queued expectation due at this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL missed cyc=%0d now=%0d", e.cyc, cyc);
            end else if ({ps, y, dir, fault} != {e.code, e.y, e.d, e.f}) begin
                errors++;
                $display("FAIL out cyc=%0d got ps=%b y=%b dir=%b fault=%b exp ps=%b y=%b dir=%b fault=%b",
                         cyc, ps, y, dir, fault, e.code, e.y, e.d, e.f);
            end
        end
    end

    task automatic exp_span(input int a, input int b, input logic [3:0] c,
                            input logic yy, input logic d, input logic f);
        exp_t e;
        for (int i = a; i <= b; i++) begin
            e.cyc = base + i;
            e.code = c;
            e.y = yy;
            e.d = d;
            e.f = f;
            q.push_back(e);
        end
    endtask

    task automatic go_to(input int off);
        while (cyc < base + off) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_a = 1'b0;
        s_b = 1'b0;
        s_c = 1'b0;
        @(negedge clk);
        base = cyc;
        exp_span(1, 1, C_IDLE, 0, 0, 0);
        go_to(1);
        rst = 1'b0;

`ifndef DEBOUNCE_EN
        // s_a trigger, full closing sequence, then occupied and cleared
        base = cyc;
        exp_span(1, 2, C_IDLE, 0, 0, 0);
        exp_span(3, 10, C_DET, 0, 0, 0);
        exp_span(11, 18, C_ALE, 0, 0, 0);
        exp_span(19, 22, C_CLO, 0, 0, 0);
        exp_span(23, 27, C_CLO, 1, 0, 0);
        exp_span(28, 31, C_CLR, 1, 0, 0);
        exp_span(32, 34, C_IDLE, 0, 0, 0);
        s_a = 1'b1;
        go_to(1);  s_a = 1'b0;
        go_to(20); s_c = 1'b1;
        go_to(22); s_b = 1'b1;
        go_to(23); s_b = 1'b0;
        go_to(25); s_c = 1'b0;
        go_to(34);

        // s_b trigger, arrival timeout, abort, fault sticks
        base = cyc;
        exp_span(1, 2, C_IDLE, 0, 0, 0);
        exp_span(3, 10, C_DET, 0, 1, 0);
        exp_span(11, 18, C_ALE, 0, 1, 0);
        exp_span(19, 82, C_CLO, 0, 1, 0);
        exp_span(83, 86, C_ABT, 1, 1, 1);
        exp_span(87, 88, C_IDLE, 0, 1, 1);
        s_b = 1'b1;
        go_to(1); s_b = 1'b0;
        go_to(88);

        // s_a and s_b together: dir=0, only s_b acts as exit sensor
        base = cyc;
        exp_span(1, 2, C_IDLE, 0, 1, 1);
        exp_span(3, 10, C_DET, 0, 0, 1);
        exp_span(11, 18, C_ALE, 0, 0, 1);
        exp_span(19, 22, C_CLO, 0, 0, 1);
        exp_span(23, 33, C_CLO, 1, 0, 1);
        exp_span(34, 37, C_CLR, 1, 0, 1);
        exp_span(38, 39, C_IDLE, 0, 0, 1);
        s_a = 1'b1;
        s_b = 1'b1;
        go_to(1);  s_a = 1'b0; s_b = 1'b0;
        go_to(20); s_c = 1'b1;
        go_to(24); s_a = 1'b1;
        go_to(25); s_a = 1'b0; s_c = 1'b0;
        go_to(30); s_b = 1'b1;
        go_to(31); s_b = 1'b0;
        go_to(39);

        // reset while occupied
        base = cyc;
        exp_span(1, 2, C_IDLE, 0, 0, 1);
        exp_span(3, 10, C_DET, 0, 1, 1);
        exp_span(11, 18, C_ALE, 0, 1, 1);
        exp_span(19, 22, C_CLO, 0, 1, 1);
        exp_span(23, 25, C_CLO, 1, 1, 1);
        exp_span(26, 27, C_IDLE, 0, 0, 0);
        s_b = 1'b1;
        go_to(1);  s_b = 1'b0;
        go_to(20); s_c = 1'b1;
        go_to(25); rst = 1'b1;
        go_to(26); rst = 1'b0; s_c = 1'b0;
        go_to(27);

        // s_c arrives in the last timeout cycle: occupancy wins
        base = cyc;
        exp_span(1, 2, C_IDLE, 0, 0, 0);
        exp_span(3, 10, C_DET, 0, 0, 0);
        exp_span(11, 18, C_ALE, 0, 0, 0);
        exp_span(19, 82, C_CLO, 0, 0, 0);
        exp_span(83, 88, C_CLO, 1, 0, 0);
        exp_span(89, 92, C_CLR, 1, 0, 0);
        exp_span(93, 94, C_IDLE, 0, 0, 0);
        s_a = 1'b1;
        go_to(1);  s_a = 1'b0;
        go_to(80); s_c = 1'b1;
        go_to(85); s_b = 1'b1;
        go_to(86); s_b = 1'b0; s_c = 1'b0;
        go_to(94);
`else
        // 2-cycle glitch is filtered out
        base = cyc;
        exp_span(1, 12, C_IDLE, 0, 0, 0);
        s_a = 1'b1;
        go_to(2);  s_a = 1'b0;
        go_to(12);

        // 3-cycle pulse passes after sync plus debounce latency
        base = cyc;
        exp_span(1, 5, C_IDLE, 0, 0, 0);
        exp_span(6, 13, C_DET, 0, 0, 0);
        exp_span(14, 15, C_ALE, 0, 0, 0);
        s_a = 1'b1;
        go_to(3);  s_a = 1'b0;
        go_to(15);
`endif

        @(negedge clk);
        @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL unchecked cyc=%0d now=%0d", e.cyc, cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
